// File: rtl/mult_wb_pkg.sv
// Shared constants and state encoding for the multiplier bus initiator.
// MULT_WB_READBACK_EN adds the operand readback states.
package mult_wb_pkg;

    localparam logic [7:0]  A_OFF    = 8'h00;
    localparam logic [7:0]  B_OFF    = 8'h04;
    localparam logic [7:0]  P_OFF    = 8'h08;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        GAP1,
        WR_B,
        GAP2,
`ifdef MULT_WB_READBACK_EN
        RD_A,
        GAP3,
        RD_B,
        GAP4,
`endif
        RD_P,
        RESP
    } state_e;

endpackage

// File: rtl/mult_wb_xfer.sv
// Single Wishbone classic transfer engine with an optional ack timeout.
// Bus outputs are registered and cleared as soon as the transfer ends.
module mult_wb_xfer #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;
    logic            expired;

    // cnt holds the number of ack-less cycles already spent in this transfer
    assign expired = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);
    assign done    = wbm_cyc_o & wbm_ack_i;
    assign timeout = wbm_cyc_o & ~wbm_ack_i & expired;
    assign rdata   = wbm_dat_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            cnt       <= '0;
        end else if (start) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= we;
            wbm_sel_o <= 4'hF;
            wbm_adr_o <= adr;
            wbm_dat_o <= wdata;
            cnt       <= '0;
        end else if (done || timeout) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            cnt       <= '0;
        end else if (wbm_cyc_o) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_wb_initiator.sv
// Host-side sequencer: write A, write B, read P from the multiplier block.
// MULT_WB_READBACK_EN verifies A and B by readback before reading P.
module mult_wb_initiator
    import mult_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 16,
    parameter int          TO_W        = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_a_i,
    input  logic [15:0] cmd_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_p_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    state_e      state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        x_start;
    logic        x_we;
    logic [31:0] x_adr;
    logic [31:0] x_wdata;
    logic        x_done;
    logic        x_to;
    logic [31:0] x_rdata;
    logic        abort;

    function automatic logic [31:0] reg_adr(input logic [7:0] off);
        return BASE_ADR + {24'h0, off};
    endfunction

    // The next transfer is launched from the state before it, so the
    // registered bus outputs line up with the bus state itself.
    always_comb begin
        x_start = 1'b0;
        x_we    = 1'b0;
        x_adr   = BASE_ADR;
        x_wdata = '0;
        case (state)
            IDLE: begin
                x_start = cmd_valid_i & cmd_ready_o;
                x_we    = 1'b1;
                x_adr   = reg_adr(A_OFF);
                x_wdata = {16'h0, cmd_a_i};
            end
            GAP1: begin
                x_start = 1'b1;
                x_we    = 1'b1;
                x_adr   = reg_adr(B_OFF);
                x_wdata = {16'h0, b_q};
            end
`ifdef MULT_WB_READBACK_EN
            GAP2: begin
                x_start = 1'b1;
                x_adr   = reg_adr(A_OFF);
            end
            GAP3: begin
                x_start = 1'b1;
                x_adr   = reg_adr(B_OFF);
            end
            GAP4: begin
                x_start = 1'b1;
                x_adr   = reg_adr(P_OFF);
            end
`else
            GAP2: begin
                x_start = 1'b1;
                x_adr   = reg_adr(P_OFF);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        abort = x_to;
`ifdef MULT_WB_READBACK_EN
        if (x_done && state == RD_A && x_rdata[15:0] != a_q)
            abort = 1'b1;
        if (x_done && state == RD_B && x_rdata[15:0] != b_q)
            abort = 1'b1;
`endif
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_p_o     <= '0;
            rsp_err_o   <= 1'b0;
        end else if (abort) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_p_o     <= ERR_DATA;
        end else begin
            case (state)
                IDLE: if (cmd_valid_i && cmd_ready_o) begin
                    a_q         <= cmd_a_i;
                    b_q         <= cmd_b_i;
                    cmd_ready_o <= 1'b0;
                    state       <= WR_A;
                end
                WR_A: if (x_done) state <= GAP1;
                GAP1: state <= WR_B;
                WR_B: if (x_done) state <= GAP2;
`ifdef MULT_WB_READBACK_EN
                GAP2: state <= RD_A;
                RD_A: if (x_done) state <= GAP3;
                GAP3: state <= RD_B;
                RD_B: if (x_done) state <= GAP4;
                GAP4: state <= RD_P;
`else
                GAP2: state <= RD_P;
`endif
                RD_P: if (x_done) begin
                    rsp_p_o     <= x_rdata;
                    rsp_err_o   <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    state       <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mult_wb_xfer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) u_xfer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .start     (x_start),
        .we        (x_we),
        .adr       (x_adr),
        .wdata     (x_wdata),
        .done      (x_done),
        .timeout   (x_to),
        .rdata     (x_rdata),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

endmodule

// File: tb/tb_mult_wb_initiator.sv
// Scoreboard bench for mult_wb_initiator with a behavioural multiplier slave.
// Honours MULT_WB_READBACK_EN for latency and the readback mismatch case.
module tb_mult_wb_initiator;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ADR_A = BASE;
    localparam logic [31:0] ADR_B = BASE + 32'h4;
    localparam logic [31:0] ADR_P = BASE + 32'h8;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;
`ifdef MULT_WB_READBACK_EN
    localparam int NBUS = 5;
`else
    localparam int NBUS = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_p;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;

    mult_wb_initiator #(
        .BASE_ADR    (BASE),
        .TIMEOUT_CYC (16),
        .TO_W        (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_a_i     (cmd_a),
        .cmd_b_i     (cmd_b),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_p_o     (rsp_p),
        .rsp_err_o   (rsp_err),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (dat_o),
        .wbm_dat_i   (dat_i),
        .wbm_ack_i   (ack)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural multiplier slave ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;
    bus_t blog[$];

    logic [15:0] reg_a = '0;
    logic [15:0] reg_b = '0;
    bit          in_x = 0;
    int          wcnt = 0;
    int          waits = 0;
    logic [31:0] s_adr, s_dat;
    logic        s_we;
    bit          rand_waits = 0;
    int          fix_waits = 0;
    bit          no_ack_p = 0;
    bit          bad_rb_a = 0;
    int          p_cyc = 0;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (a == ADR_A)
            return {16'h0, bad_rb_a ? reg_a + 16'd1 : reg_a};
        if (a == ADR_B)
            return {16'h0, reg_b};
        if (a == ADR_P)
            return {16'h0, reg_a} * {16'h0, reg_b};
        return 32'h0BAD_0BAD;
    endfunction

    always @(negedge clk) begin
        bus_t e;
        ack = 1'b0;
        dat_i = $urandom;
        if (cyc && stb) begin
            if (adr == ADR_P) p_cyc++;
            if (!in_x) begin
                in_x = 1;
                wcnt = 0;
                s_adr = adr;
                s_dat = dat_o;
                s_we = we;
                waits = rand_waits ? int'($urandom_range(0, 3)) : fix_waits;
                chk("sel", {28'h0, sel}, 32'hF);
            end else begin
                chk("hold_adr", adr, s_adr);
                chk("hold_dat", dat_o, s_dat);
                chk("hold_we", {31'h0, we}, {31'h0, s_we});
            end
            if (!(no_ack_p && adr == ADR_P)) begin
                if (wcnt == waits) begin
                    ack = 1'b1;
                    e.we = we;
                    e.adr = adr;
                    e.dat = dat_o;
                    blog.push_back(e);
                    if (we) begin
                        if (adr == ADR_A) reg_a = dat_o[15:0];
                        if (adr == ADR_B) reg_b = dat_o[15:0];
                    end else begin
                        dat_i = slave_rd(adr);
                    end
                end else begin
                    wcnt++;
                end
            end
        end else begin
            in_x = 0;
        end
    end

    // ---------------- response consumer ----------------
    bit rand_rdy = 0;
    int rdy_dly = 0;
    int dly_left = 0;

    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            if (dly_left > 0) begin
                rsp_ready = 1'b0;
                dly_left--;
            end else begin
                rsp_ready = 1'b1;
            end
        end else begin
            rsp_ready = 1'b0;
            dly_left = rand_rdy ? int'($urandom_range(0, 3)) : rdy_dly;
        end
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [31:0] p;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    bit          seen = 0;
    logic [31:0] h_p;
    logic        h_err;
    int          hs_cyc = 0;
    int          last_acc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || !rsp_valid) begin
            seen = 0;
        end else begin
            chk("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
            if (!seen) begin
                seen = 1;
                h_p = rsp_p;
                h_err = rsp_err;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got p=%h, want none", rsp_p);
                end else if (sb[0].lat >= 0) begin
                    chk("latency", cyc_n - sb[0].acc, sb[0].lat);
                end
            end else begin
                chk("hold_rsp_p", rsp_p, h_p);
                chk("hold_rsp_err", {31'h0, rsp_err}, {31'h0, h_err});
            end
            if (rsp_ready) begin
                seen = 0;
                hs_cyc = cyc_n;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("rsp_p", rsp_p, e.p);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input bit exp_rsp, input int lat,
                        input logic [31:0] ep, input logic ee);
        int   n = 0;
        exp_t e;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: got ready=0, want 1");
            cmd_valid = 1'b0;
            return;
        end
        last_acc = cyc_n;
        if (exp_rsp) begin
            e.p = ep;
            e.err = ee;
            e.lat = lat;
            e.acc = cyc_n;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a = 16'($urandom);
        cmd_b = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 600) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", {31'h0, cyc}, 0);
        chk("rst_stb", {31'h0, stb}, 0);
        chk("rst_we", {31'h0, we}, 0);
        chk("rst_sel", {28'h0, sel}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 0);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // zero-wait slave, 3 * 5
        blog.delete();
        send(16'd3, 16'd5, 1, 2 * NBUS, 32'h0000_000F, 1'b0);
        drain();
        chk("log_size", blog.size(), NBUS);
        if (blog.size() == NBUS) begin
            chk("wr_a_adr", blog[0].adr, ADR_A);
            chk("wr_a_dat", blog[0].dat, 32'h3);
            chk("wr_a_we", {31'h0, blog[0].we}, 1);
            chk("wr_b_adr", blog[1].adr, ADR_B);
            chk("wr_b_dat", blog[1].dat, 32'h5);
            chk("rd_p_adr", blog[NBUS-1].adr, ADR_P);
            chk("rd_p_we", {31'h0, blog[NBUS-1].we}, 0);
            chk("rd_p_dat", blog[NBUS-1].dat, 0);
        end

        // three wait states per transfer, max operands
        fix_waits = 3;
        send(16'hFFFF, 16'hFFFF, 1, 5 * NBUS, 32'hFFFE_0001, 1'b0);
        drain();
        fix_waits = 0;

        // slave never acks the product read
        no_ack_p = 1;
        p_cyc = 0;
        send(16'd7, 16'd9, 1, 2 * NBUS - 1 + 16, BAD, 1'b1);
        drain();
        chk("timeout_cycles", p_cyc, 16);
        no_ack_p = 0;

        // stalled consumer, second command held pending
        rdy_dly = 5;
        send(16'h1234, 16'h0056, 1, 2 * NBUS, 32'h1234 * 32'h56, 1'b0);
        send(16'h00AB, 16'h00CD, 1, 2 * NBUS, 32'hAB * 32'hCD, 1'b0);
        chk("accept_after_hs", last_acc, hs_cyc + 1);
        drain();
        rdy_dly = 0;

        // reset pulse during WR_B
        send(16'd11, 16'd13, 0, -1, 0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(cyc && adr == ADR_B) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr_b", {31'h0, cyc}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'h0, cyc}, 0);
        chk("arst_stb", {31'h0, stb}, 0);
        chk("arst_rsp_valid", {31'h0, rsp_valid}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'h0, cmd_ready}, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_no_rsp", {31'h0, rsp_valid}, 0);
        chk("post_rst_cyc", {31'h0, cyc}, 0);

`ifdef MULT_WB_READBACK_EN
        // corrupted A readback must abort before the product read
        bad_rb_a = 1;
        p_cyc = 0;
        send(16'd3, 16'd5, 1, 6, BAD, 1'b1);
        drain();
        chk("rb_no_p_read", p_cyc, 0);
        bad_rb_a = 0;
`endif

        // boundary operands, zero wait
        send(16'h0000, 16'hFFFF, 1, 2 * NBUS, 32'h0, 1'b0);
        send(16'h8000, 16'h0002, 1, 2 * NBUS, 32'h0001_0000, 1'b0);
        drain();

        // randomized traffic
        rand_waits = 1;
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, 1, -1, {16'h0, ra} * {16'h0, rb}, 1'b0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
